// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks take priority, and MDU
// results are buffered in a small FIFO and drained into idle write slots.
module rf_wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_valid,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DW-1:0]            wb_data,
    input  logic                     md_valid,
    input  logic [AW-1:0]            md_addr,
    input  logic [DW-1:0]            md_data,
    output logic                     md_ready,
    output logic                     wren,
    output logic [AW-1:0]            wraddr,
    output logic [DW-1:0]            wrdata,
    input  logic [AW-1:0]            q1addr,
    input  logic [AW-1:0]            q2addr,
    output logic                     pend1,
    output logic                     pend2,
    output logic [$clog2(DEPTH):0]   md_level
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    logic [DEPTH-1:0] live_q, live_d;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    logic slot_busy;
    logic head_valid;
    logic head_live;
    logic pop;
    logic push_write;

    assign slot_busy  = wb_valid && (wb_addr != '0);
    assign head_valid = (level_q != '0);
    assign head_live  = head_valid && live_q[rd_ptr_q];
    // Killed heads are discarded even under a busy slot; live heads wait for a free one.
    assign pop        = head_valid && (!head_live || !slot_busy);
    assign md_ready   = (level_q < LW'(DEPTH));
    assign push_write = md_valid && md_ready && (md_addr != '0);
    assign md_level   = level_q;

    // Write-port mux; gated by reset so a held wb_valid cannot write during reset.
    always_comb begin
        wren   = 1'b0;
        wraddr = addr_q[rd_ptr_q];
        wrdata = data_q[rd_ptr_q];
        if (slot_busy) begin
            wren   = rst_n;
            wraddr = wb_addr;
            wrdata = wb_data;
        end else if (head_live) begin
            wren   = rst_n;
        end
    end

    // Live bits are cleared on pop, so only occupied entries can match.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (addr_q[i] == q1addr)) pend1 = 1'b1;
            if (live_q[i] && (addr_q[i] == q2addr)) pend2 = 1'b1;
        end
        if (q1addr == '0) pend1 = 1'b0;
        if (q2addr == '0) pend2 = 1'b0;
    end

    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // A younger pipeline write supersedes every older queued result to the same register.
        if (slot_busy) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == wb_addr) live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PW'(1);
        end
        if (push_write) begin
            live_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q] = md_addr;
            data_d[wr_ptr_q] = md_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push_write) - LW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            live_q   <= live_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a small register-file model on the falling edge.
module tb_rf_wb_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          md_valid;
    logic [AW-1:0] md_addr;
    logic [DW-1:0] md_data;
    logic          md_ready;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [DW-1:0] wrdata;
    logic [AW-1:0] q1addr;
    logic [AW-1:0] q2addr;
    logic          pend1;
    logic          pend2;
    logic [2:0]    md_level;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rf [32];
    int stale7_writes = 0;
    int flushed_writes = 0;

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data), .md_ready(md_ready),
        .wren(wren), .wraddr(wraddr), .wrdata(wrdata),
        .q1addr(q1addr), .q2addr(q2addr), .pend1(pend1), .pend2(pend2),
        .md_level(md_level)
    );

    always #5 clk = ~clk;

    // Register file commits on the falling edge.
    always @(negedge clk) begin
        if (wren) begin
            rf[wraddr] = wrdata;
            if (wraddr == 5'd7 && wrdata == 32'hAAAA) stale7_writes++;
            if (wraddr >= 5'd20 && wraddr <= 5'd22) flushed_writes++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        q1addr = 5'd5; q2addr = 5'd0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if (md_ready !== 1'b1 || md_level !== 3'd0 || wren !== 1'b0 || pend1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ready=%b level=%0d wren=%b pend1=%b, want 1 0 0 0",
                     md_ready, md_level, wren, pend1);
        end
        tick();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h11;
        #1;
        tests++;
        if (wren !== 1'b1 || wraddr !== 5'd5 || wrdata !== 32'h11) begin
            fails++;
            $display("FAIL wb_passthrough: wren=%b addr=%0d data=%h, want 1 5 11", wren, wraddr, wrdata);
        end
    endtask

    task automatic test_drain();
        tick();
        idle_inputs();
        md_valid = 1'b1; md_addr = 5'd9; md_data = 32'hDEAD; q1addr = 5'd9;
        #1;
        tests++;
        if (pend1 !== 1'b0 || md_ready !== 1'b1) begin
            fails++;
            $display("FAIL drain_incoming: pend1=%b ready=%b, want 0 1", pend1, md_ready);
        end
        tick();
        md_valid = 1'b0;
        #1;
        tests++;
        if (wren !== 1'b1 || wraddr !== 5'd9 || wrdata !== 32'hDEAD || pend1 !== 1'b1 || md_level !== 3'd1) begin
            fails++;
            $display("FAIL drain_write: wren=%b addr=%0d data=%h pend1=%b level=%0d, want 1 9 dead 1 1",
                     wren, wraddr, wrdata, pend1, md_level);
        end
        tick();
        #1;
        tests++;
        if (wren !== 1'b0 || pend1 !== 1'b0 || md_level !== 3'd0) begin
            fails++;
            $display("FAIL drain_after: wren=%b pend1=%b level=%0d, want 0 0 0", wren, pend1, md_level);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 6; i++) begin
            tick();
            wb_valid = 1'b1; wb_addr = 5'(i + 1); wb_data = 32'h50 + 32'(i);
            md_valid = (i < 5);
            md_addr  = (i < 4) ? 5'(10 + i) : 5'd14;
            md_data  = (i < 4) ? 32'h100 + 32'(i) : 32'h104;
            #1;
            tests++;
            if (wren !== 1'b1 || wraddr !== 5'(i + 1) || wrdata !== 32'h50 + 32'(i) ||
                md_level !== 3'((i < 4) ? i : 4) || md_ready !== (i < 4)) begin
                fails++;
                $display("FAIL fill_cycle%0d: wren=%b addr=%0d data=%h level=%0d ready=%b", i, wren, wraddr,
                         wrdata, md_level, md_ready);
            end
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            idle_inputs();
            #1;
            tests++;
            if (wren !== 1'b1 || wraddr !== 5'(10 + j) || wrdata !== 32'h100 + 32'(j) ||
                md_level !== 3'(4 - j) || md_ready !== (j > 0)) begin
                fails++;
                $display("FAIL fill_drain%0d: wren=%b addr=%0d data=%h level=%0d ready=%b, want 1 %0d %h %0d %b",
                         j, wren, wraddr, wrdata, md_level, md_ready, 10 + j, 32'h100 + 32'(j), 4 - j, j > 0);
            end
        end
        tick();
        #1;
        tests++;
        if (wren !== 1'b0 || md_level !== 3'd0) begin
            fails++;
            $display("FAIL fill_empty: wren=%b level=%0d, want 0 0", wren, md_level);
        end
    endtask

    task automatic test_kill();
        stale7_writes = 0;
        tick();
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
        md_valid = 1'b1; md_addr = 5'd7; md_data = 32'hAAAA; q1addr = 5'd7;
        tick();
        md_valid = 1'b0;
        wb_addr = 5'd7; wb_data = 32'hBBBB;
        #1;
        tests++;
        if (pend1 !== 1'b1 || md_level !== 3'd1 || wren !== 1'b1 || wraddr !== 5'd7 || wrdata !== 32'hBBBB) begin
            fails++;
            $display("FAIL kill_blocked: pend1=%b level=%0d wren=%b addr=%0d data=%h, want 1 1 1 7 bbbb",
                     pend1, md_level, wren, wraddr, wrdata);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (wren !== 1'b0 || pend1 !== 1'b0 || md_level !== 3'd1) begin
            fails++;
            $display("FAIL kill_discard: wren=%b pend1=%b level=%0d, want 0 0 1", wren, pend1, md_level);
        end
        tick();
        #1;
        tests++;
        if (md_level !== 3'd0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL kill_empty: level=%0d wren=%b, want 0 0", md_level, wren);
        end
        tick();
        tests++;
        if (rf[7] !== 32'hBBBB || stale7_writes != 0) begin
            fails++;
            $display("FAIL kill_rf: r7=%h stale_writes=%0d, want bbbb 0", rf[7], stale7_writes);
        end
        // Same-cycle push to the register being written is younger and must survive.
        wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 32'h88;
        md_valid = 1'b1; md_addr = 5'd8; md_data = 32'hCC;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (wren !== 1'b1 || wraddr !== 5'd8 || wrdata !== 32'hCC) begin
            fails++;
            $display("FAIL kill_younger: wren=%b addr=%0d data=%h, want 1 8 cc", wren, wraddr, wrdata);
        end
    endtask

    task automatic test_r0();
        tick();
        idle_inputs();
        md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hFFFF;
        tick();
        md_valid = 1'b0;
        #1;
        tests++;
        if (md_level !== 3'd0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL r0_push: level=%0d wren=%b, want 0 0", md_level, wren);
        end
        wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h22;
        md_valid = 1'b1; md_addr = 5'd4; md_data = 32'h44; q2addr = 5'd4;
        tick();
        md_valid = 1'b0;
        wb_addr = 5'd0; wb_data = 32'h99;
        #1;
        tests++;
        if (wren !== 1'b1 || wraddr !== 5'd4 || wrdata !== 32'h44 || pend2 !== 1'b1) begin
            fails++;
            $display("FAIL r0_wb: wren=%b addr=%0d data=%h pend2=%b, want 1 4 44 1", wren, wraddr, wrdata, pend2);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (md_level !== 3'd0 || pend2 !== 1'b0) begin
            fails++;
            $display("FAIL r0_after: level=%0d pend2=%b, want 0 0", md_level, pend2);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            tick();
            wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
            md_valid = 1'b1; md_addr = 5'(20 + i); md_data = 32'h200 + 32'(i);
        end
        tick();
        md_valid = 1'b0;
        q1addr = 5'd20;
        #1;
        tests++;
        if (md_level !== 3'd3 || pend1 !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: level=%0d pend1=%b, want 3 1", md_level, pend1);
        end
        flushed_writes = 0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (wren !== 1'b0 || md_level !== 3'd0 || pend1 !== 1'b0 || md_ready !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_assert: wren=%b level=%0d pend1=%b ready=%b, want 0 0 0 1",
                     wren, md_level, pend1, md_ready);
        end
        tick();
        wb_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) tick();
        tests++;
        if (flushed_writes != 0 || md_level !== 3'd0 || wren !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_after: flushed_writes=%0d level=%0d wren=%b, want 0 0 0",
                     flushed_writes, md_level, wren);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        test_reset();
        test_drain();
        test_fill();
        test_kill();
        test_r0();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

- Writer side of the integer register file.
- Merges two write sources onto the file's single write port (wraddr/wrdata/wren), which commits on the falling clock edge:
  - the in-order pipeline writeback stream;
  - a long-latency result stream (multiply/divide unit, MDU).
- Pipeline writebacks always have priority and never stall. MDU results are buffered in a small FIFO and drained into idle write slots.
- Exposes pending-write lookups so the decode stage can stall on operands whose MDU result is still queued.

## Interface
- DEPTH, 4, MDU result FIFO entries; power of two, 2..16
- AW, 5, register address width
- DW, 32, data width
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- wb_valid  input  1  pipeline writeback present this cycle
- wb_addr  input  AW  pipeline destination register
- wb_data  input  DW  pipeline result
- md_valid  input  1  MDU result offered
- md_addr  input  AW  MDU destination register
- md_data  input  DW  MDU result
- md_ready  output  1  FIFO can accept; transfer when md_valid && md_ready
- wren  output  1  register-file write enable (combinational)
- wraddr  output  AW  register-file write address (combinational)
- wrdata  output  DW  register-file write data (combinational)
- q1addr, q2addr  input  AW  decode operand addresses for hazard lookup
- pend1, pend2  output  1  operand has a live queued MDU write (combinational)
- md_level  output  log2(DEPTH)+1  FIFO occupancy

## Operation

**Pipeline slot**
- The pipeline slot is busy when wb_valid && wb_addr != 0.
- When busy: wren=1, wraddr=wb_addr, wrdata=wb_data.
- A pipeline write to r0 leaves the slot free.

**FIFO entries and push**
- Each FIFO entry holds {live, addr, data}.
- Push on md_valid && md_ready:
  - md_addr == 0: accepted and dropped, no entry written.
  - Otherwise: the entry is written with live=1.
- md_ready = (md_level < DEPTH). It depends on registered state only, not on a same-cycle pop.

**Drain, one pop per cycle maximum**
- Head not live (killed): popped regardless of pipeline slot state. No write is issued for it.
- Head live and pipeline slot free: wren=1, wraddr/wrdata = head; head popped.
- Head live and pipeline slot busy: head held.

**Kill rule (ordering)**
- A busy pipeline write clears live on every queued entry with addr == wb_addr.
- Rationale: the pipeline write is younger and must not be clobbered by a later drain of an older MDU result.
- An MDU entry pushed in the same cycle is younger and is not killed.

**Pending lookup**
- pendN = (qNaddr != 0) && (some queued entry is live with addr == qNaddr).
- The incoming md beat is not included in the lookup.
- A head being drained this cycle still reports pend. The RF commits at the falling edge, so decode sees the new value from the next cycle; holding pend for that cycle is a conservative one-cycle stall.

**Occupancy**
- md_level = pushes minus pops; range 0..DEPTH.
- Simultaneous push and pop leave the level unchanged.
- Pointers wrap modulo DEPTH.

**Reset (any time, including mid-drain)**
- Queued contents are discarded.
- md_level=0, md_ready=1 after reset release.
- wren is 0 while rst_n is low, even if wb_valid is high.
- pend1/pend2=0.

## Timing
- Pipeline write: wren asserted in the same cycle as wb_valid; RF commits at that cycle's falling edge. Zero added latency.
- MDU result accepted at rising edge k:
  - earliest drain is cycle k (the cycle after edge k);
  - RF commit at that cycle's falling edge;
  - pend for that register visible from cycle k.
- Back-to-back MDU pushes are sustained at one per cycle while not full.
- Drain throughput: one live write per free slot; one killed entry discarded per cycle.
- Full FIFO with a pop in cycle k: md_ready rises in cycle k+1.

## Test plan
- Reset then idle:
  - md_ready=1, md_level=0, wren=0, pend=0.
  - wb_valid=1, addr 5, data 0x11 → wren=1, wraddr=5, wrdata=0x11 in the same cycle.
- MDU drain into idle slots:
  - push {addr 9, 0xDEAD} with wb_valid=0;
  - next cycle wren=1, wraddr=9, wrdata=0xDEAD; md_level returns to 0.
  - pend for q1addr=9 is high until the pop, then low.
- Priority and fill:
  - wb_valid held with nonzero addresses for 6 cycles while 5 MDU results are offered;
  - md_ready drops after 4 accepted, md_level=4;
  - drains start on the first wb-idle cycle, in order, one per cycle.
- Kill:
  - queue {addr 7, 0xAAAA}, then pipeline writes {7, 0xBBBB} while the head is blocked;
  - queued entry dropped with no later write to 7;
  - RF r7 ends at 0xBBBB; pend for 7 clears.
- r0 handling:
  - md push to addr 0 → md_level unchanged.
  - wb write to addr 0 with a live head → head drains that cycle.
- Reset mid-operation:
  - assert rst_n low with 3 entries queued and wb_valid=1;
  - wren=0 immediately; md_level=0;
  - no queued write appears after release.
